axi_lite_joy_regs: RTL

AXI4-Lite slave register file for the joystick ADC IP. It is the responder end of the S00_AXI interface driven by the master VIP in the IP-level bench. It holds control and scratch registers and captures X/Y samples from the ADC front end. It raises a sticky new-sample flag and an optional interrupt for the PS.

---
 rtl/axi_lite_joy_regs_if.sv | 42 ++++
 rtl/axi_lite_joy_regs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_joy_regs_if.sv
// AXI4-Lite bus bundle between the PS-side master and the joystick register file.
// Signal names follow the AXI channel naming used by the IP-level bench.
interface axi_lite_joy_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   AWADDR;
    logic [2:0]          AWPROT;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic [2:0]          ARPROT;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi_lite_joy_regs.sv
// AXI4-Lite register file for the joystick ADC: CTRL, SCRATCH, captured X/Y SAMPLE
// and a STATUS word with sticky new-sample/overrun flags and a sample counter.
module axi_lite_joy_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int ADC_WIDTH          = 12
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_lite_joy_regs_if.slave   s00_axi,
    input  logic [ADC_WIDTH-1:0] adc_x,
    input  logic [ADC_WIDTH-1:0] adc_y,
    input  logic                 adc_valid,
    output logic                 adc_enable,
    output logic                 irq
);

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic                 ready_en_r;
    logic                 aw_held_r;
    logic                 w_held_r;
    logic                 bvalid_r;
    logic [1:0]           aw_idx_r;
    logic [31:0]          wdata_r;
    logic [3:0]           wstrb_r;
    logic                 rvalid_r;
    logic [31:0]          rdata_r;
    logic [31:0]          ctrl_r;
    logic [31:0]          scratch_r;
    logic [ADC_WIDTH-1:0] sample_x_r;
    logic [ADC_WIDTH-1:0] sample_y_r;
    logic                 new_sample_r;
    logic                 overrun_r;
    logic [15:0]          sample_count_r;
    logic                 irq_r;

    logic        awready_s;
    logic        wready_s;
    logic        arready_s;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        ar_hs_s;
    logic        wr_do_s;
    logic        capture_s;
    logic        w1c_s;
    logic        ns_clr_s;
    logic        ov_clr_s;
    logic        ov_set_s;
    logic [31:0] sample_word_s;
    logic [31:0] rd_mux_s;
    logic        unused_s;

    // Readies stay low in reset and for the first cycle after release.
    assign awready_s = ready_en_r && !aw_held_r && !bvalid_r;
    assign wready_s  = ready_en_r && !w_held_r && !bvalid_r;
    assign arready_s = ready_en_r && !rvalid_r;
    assign aw_hs_s   = s00_axi.AWVALID && awready_s;
    assign w_hs_s    = s00_axi.WVALID && wready_s;
    assign ar_hs_s   = s00_axi.ARVALID && arready_s;
    assign wr_do_s   = aw_held_r && w_held_r;

    assign s00_axi.AWREADY = awready_s;
    assign s00_axi.WREADY  = wready_s;
    assign s00_axi.ARREADY = arready_s;
    assign s00_axi.BVALID  = bvalid_r;
    assign s00_axi.BRESP   = 2'b00;
    assign s00_axi.RVALID  = rvalid_r;
    assign s00_axi.RDATA   = rdata_r;
    assign s00_axi.RRESP   = 2'b00;
    assign adc_enable      = ctrl_r[0];
    assign irq             = irq_r;

    assign unused_s = ^{s00_axi.AWPROT, s00_axi.ARPROT, s00_axi.AWADDR, s00_axi.ARADDR};

    // Capture and clear sources; a capture always beats a clear in the same cycle.
    assign capture_s = adc_valid && ctrl_r[0];
    assign w1c_s     = wr_do_s && (aw_idx_r == 2'd3) && wstrb_r[0];
    assign ns_clr_s  = (ar_hs_s && (s00_axi.ARADDR[3:2] == 2'd2)) || (w1c_s && wdata_r[0]);
    assign ov_clr_s  = w1c_s && wdata_r[1];
    assign ov_set_s  = capture_s && new_sample_r && !ns_clr_s;

    // Ready enable: one cycle of quiet after reset release.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Write channel: AW and W are latched independently, then committed together.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            aw_idx_r  <= 2'd0;
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                aw_idx_r  <= s00_axi.AWADDR[3:2];
            end else if (wr_do_s) begin
                aw_held_r <= 1'b0;
            end else begin
                aw_held_r <= aw_held_r;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                wdata_r  <= s00_axi.WDATA;
                wstrb_r  <= s00_axi.WSTRB;
            end else if (wr_do_s) begin
                w_held_r <= 1'b0;
            end else begin
                w_held_r <= w_held_r;
            end
            if (wr_do_s) begin
                bvalid_r <= 1'b1;
            end else if (s00_axi.BREADY) begin
                bvalid_r <= 1'b0;
            end else begin
                bvalid_r <= bvalid_r;
            end
        end
    end

    // CTRL and SCRATCH byte-lane writes.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_r    <= 32'd0;
            scratch_r <= 32'd0;
        end else if (wr_do_s && (aw_idx_r == 2'd0)) begin
            ctrl_r <= apply_strb(ctrl_r, wdata_r, wstrb_r);
        end else if (wr_do_s && (aw_idx_r == 2'd1)) begin
            scratch_r <= apply_strb(scratch_r, wdata_r, wstrb_r);
        end else begin
            ctrl_r    <= ctrl_r;
            scratch_r <= scratch_r;
        end
    end

    // Sample capture, sticky flags and the wrapping sample counter.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sample_x_r     <= '0;
            sample_y_r     <= '0;
            new_sample_r   <= 1'b0;
            overrun_r      <= 1'b0;
            sample_count_r <= 16'd0;
        end else begin
            if (capture_s) begin
                sample_x_r     <= adc_x;
                sample_y_r     <= adc_y;
                new_sample_r   <= 1'b1;
                sample_count_r <= sample_count_r + 16'd1;
            end else begin
                new_sample_r   <= ns_clr_s ? 1'b0 : new_sample_r;
                sample_count_r <= sample_count_r;
            end
            if (ov_set_s) begin
                overrun_r <= 1'b1;
            end else if (ov_clr_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Interrupt follows the registered flag, one cycle behind it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ctrl_r[1] & new_sample_r;
        end
    end

    // SAMPLE word layout: X in the low half, Y in the high half.
    always_comb begin
        sample_word_s = 32'd0;
        sample_word_s[ADC_WIDTH-1:0]  = sample_x_r;
        sample_word_s[16 +: ADC_WIDTH] = sample_y_r;
    end

    // Read mux sampled on the AR handshake.
    always_comb begin
        rd_mux_s = 32'd0;
        case (s00_axi.ARADDR[3:2])
            2'd0:    rd_mux_s = ctrl_r;
            2'd1:    rd_mux_s = scratch_r;
            2'd2:    rd_mux_s = sample_word_s;
            2'd3:    rd_mux_s = {sample_count_r, 14'd0, overrun_r, new_sample_r};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read channel: data registered on AR, held until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'd0;
        end else if (ar_hs_s) begin
            rvalid_r <= 1'b1;
            rdata_r  <= rd_mux_s;
        end else if (rvalid_r && s00_axi.RREADY) begin
            rvalid_r <= 1'b0;
            rdata_r  <= rdata_r;
        end else begin
            rvalid_r <= rvalid_r;
            rdata_r  <= rdata_r;
        end
    end

endmodule
